// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
//   Sequencing controller for an up-counting interval timer. A start pulse
//   latches the period, prescale and mode, and the counter then advances once
//   every (prescale+1) clocks. When an advance finds the counter at the period
//   value, that is an expiry. An expiry raises tick for one cycle and bumps the
//   expiry counter. It then either reloads the counter (periodic mode) or parks
//   in DONE (one-shot mode).
//
// Ports
//   clk       in   1           system clock, rising edge
//   rst       in   1           asynchronous, active-high reset
//   start     in   1           pulse: latch config and begin timing (IDLE/DONE only)
//   abort     in   1           pulse: stop immediately, return to IDLE
//   periodic  in   1           1 = auto-reload, 0 = one-shot (latched on start)
//   period    in   WIDTH       terminal count P (latched on start)
//   prescale  in   PRESCALE_W  divider S, advance every S+1 cycles (latched on start)
//   busy      out  1           high while in RUN
//   done      out  1           one-shot finished, held until start/abort
//   tick      out  1           one-cycle expiry pulse
//   count     out  WIDTH       current counter value
//   expiries  out  EXP_W       expiries since last start, wraps
//
// Control interface: start and abort are single-cycle command pulses, and no
// handshake is returned. A command is acted on at the rising edge where it is
// sampled high. abort beats start. A start seen while busy is dropped. Every
// output is a register, so each one changes only on a clock edge or on reset.
// -----------------------------------------------------------------------------
module interval_timer_ctrl #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 8,
   parameter int EXP_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  periodic,
   input  logic [WIDTH-1:0]      period,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  busy,
   output logic                  done,
   output logic                  tick,
   output logic [WIDTH-1:0]      count,
   output logic [EXP_W-1:0]      expiries
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q,    state_d;
   logic [WIDTH-1:0]        count_q,    count_d;
   logic [PRESCALE_W-1:0]   presc_q,    presc_d;
   logic [EXP_W-1:0]        exp_q,      exp_d;
   logic                    busy_q,     busy_d;
   logic                    done_q,     done_d;
   logic                    tick_q,     tick_d;
   // Configuration latched at start; bus inputs are ignored while running.
   logic [WIDTH-1:0]        period_q,   period_d;
   logic [PRESCALE_W-1:0]   presc_cfg_q, presc_cfg_d;
   logic                    periodic_q, periodic_d;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      presc_d     = presc_q;
      exp_d       = exp_q;
      busy_d      = busy_q;
      done_d      = done_q;
      tick_d      = 1'b0;   // tick only ever lasts the cycle after an expiry
      period_d    = period_q;
      presc_cfg_d = presc_cfg_q;
      periodic_d  = periodic_q;

      if (abort) begin
         state_d = S_IDLE;
         count_d = '0;
         presc_d = '0;
         exp_d   = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end else if (start && (state_q != S_RUN)) begin
         period_d    = period;
         presc_cfg_d = prescale;
         periodic_d  = periodic;
         count_d     = '0;
         presc_d     = '0;
         exp_d       = '0;
         done_d      = 1'b0;
         busy_d      = 1'b1;
         state_d     = S_RUN;
      end else if (state_q == S_RUN) begin
         if (presc_q != presc_cfg_q) begin
            presc_d = presc_q + PRESCALE_W'(1);
         end else begin
            // Advance. The compare runs before the increment, so count never
            // goes past the period, even when the period is all ones.
            presc_d = '0;
            if (count_q != period_q) begin
               count_d = count_q + WIDTH'(1);
            end else begin
               tick_d = 1'b1;
               exp_d  = exp_q + EXP_W'(1);
               if (periodic_q) begin
                  count_d = '0;
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         presc_q     <= '0;
         exp_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tick_q      <= 1'b0;
         period_q    <= '0;
         presc_cfg_q <= '0;
         periodic_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         presc_q     <= presc_d;
         exp_q       <= exp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tick_q      <= tick_d;
         period_q    <= period_d;
         presc_cfg_q <= presc_cfg_d;
         periodic_q  <= periodic_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign tick     = tick_q;
   assign count    = count_q;
   assign expiries = exp_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        periodic;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        busy;
  logic        done;
  logic        tick;
  logic [15:0] count;
  logic [7:0]  expiries;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cyc = '0;
  logic [31:0] e0;

  // scoreboard: expected tick cycle and expected expiries value at that tick
  logic [31:0] exp_cyc_q[$];
  logic [7:0]  exp_xp_q[$];

  interval_timer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .periodic (periodic),
    .period   (period),
    .prescale (prescale),
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .count    (count),
    .expiries (expiries)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic pulse_start(input logic [15:0] p, input logic [7:0] s, input logic per);
    period   = p;
    prescale = s;
    periodic = per;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    e0       = cyc;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic push_ticks(input int n, input int spacing);
    for (int k = 1; k <= n; k++) begin
      exp_cyc_q.push_back(e0 + 32'(k * spacing));
      exp_xp_q.push_back(8'(k));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitor: every tick must match the head of the expected queue
  always @(negedge clk) begin
    if (tick !== 1'b0) begin
      if (exp_cyc_q.size() == 0) begin
        check("unexpected_tick", {31'd0, tick}, 32'd0);
      end else begin
        check("tick_cycle", cyc, exp_cyc_q.pop_front());
        check("tick_expiries", {24'd0, expiries}, {24'd0, exp_xp_q.pop_front()});
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_count"}, {16'd0, count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_exp"}, {24'd0, expiries}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    periodic = 1'b0; period = '0; prescale = '0;
    wait_cyc(2);
    check_idle("reset");
    check("reset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    wait_cyc(1);

    // mid-RUN async reset, P=10 S=2
    pulse_start(16'd10, 8'd2, 1'b1);
    wait_cyc(5);
    check("prerst_count", {16'd0, count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(40);
    check_idle("after_rst");

    // one-shot P=3 S=0
    pulse_start(16'd3, 8'd0, 1'b0);
    push_ticks(1, 4);
    check("os_e0_count", {16'd0, count}, 32'd0);
    check("os_e0_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(1);
      check("os_count", {16'd0, count}, 32'(k));
      check("os_busy", {31'd0, busy}, 32'd1);
    end
    wait_cyc(1);
    check("os_done", {31'd0, done}, 32'd1);
    check("os_busy_end", {31'd0, busy}, 32'd0);
    wait_cyc(3);
    check("os_hold_count", {16'd0, count}, 32'd3);
    check("os_hold_done", {31'd0, done}, 32'd1);
    check("os_q_empty", 32'(exp_cyc_q.size()), 32'd0);

    // restart from DONE, P=1 S=1 one-shot
    pulse_start(16'd1, 8'd1, 1'b0);
    push_ticks(1, 4);
    check("rs_done_clr", {31'd0, done}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd1);
    check("rs_exp_clr", {24'd0, expiries}, 32'd0);
    wait_cyc(4);
    check("rs_done", {31'd0, done}, 32'd1);
    check("rs_count", {16'd0, count}, 32'd1);
    wait_cyc(1);
    check("rs_q_empty", 32'(exp_cyc_q.size()), 32'd0);

    // periodic P=4 S=2: spacing 15
    pulse_start(16'd4, 8'd2, 1'b1);
    push_ticks(5, 15);
    wait_cyc(7);
    check("per_count7", {16'd0, count}, 32'd2);
    wait_cyc(68);
    check("per_expiries", {24'd0, expiries}, 32'd5);
    check("per_busy", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("per_q_empty", 32'(exp_cyc_q.size()), 32'd0);
    pulse_abort();
    check_idle("per_abort");

    // degenerate P=0 S=0 periodic: tick every cycle, expiries wraps
    pulse_start(16'd0, 8'd0, 1'b1);
    push_ticks(260, 1);
    wait_cyc(256);
    check("deg_wrap", {24'd0, expiries}, 32'd0);
    wait_cyc(4);
    pulse_abort();
    check_idle("deg_abort");
    check("deg_q_empty", 32'(exp_cyc_q.size()), 32'd0);

    // start during RUN is ignored: P=2 S=1 periodic, spacing 6
    pulse_start(16'd2, 8'd1, 1'b1);
    push_ticks(4, 6);
    wait_cyc(8);
    pulse_start(16'd9, 8'd3, 1'b0);
    wait_cyc(15);
    check("ign_expiries", {24'd0, expiries}, 32'd4);
    wait_cyc(1);
    check("ign_q_empty", 32'(exp_cyc_q.size()), 32'd0);
    pulse_abort();

    // start+abort in the same cycle while running
    pulse_start(16'd5, 8'd0, 1'b1);
    wait_cyc(3);
    check("sa_pre_count", {16'd0, count}, 32'd3);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("sa_now");
    wait_cyc(10);
    check_idle("sa_later");

    // max range one-shot P=FFFF S=0
    pulse_start(16'hFFFF, 8'd0, 1'b0);
    push_ticks(1, 65536);
    wait_cyc(65535);
    check("max_count", {16'd0, count}, 32'h0000FFFF);
    check("max_busy", {31'd0, busy}, 32'd1);
    check("max_done_pre", {31'd0, done}, 32'd0);
    wait_cyc(1);
    check("max_done", {31'd0, done}, 32'd1);
    wait_cyc(3);
    check("max_hold", {16'd0, count}, 32'h0000FFFF);
    check("max_q_empty", 32'(exp_cyc_q.size()), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
